pipeline_ctrl: RTL



---
 rtl/riscv_ctrl_pkg.sv | 22 ++
 rtl/sat_counter.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the core pipeline sequencer: state encoding,
// default timing constants and a counter-width helper.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } ctrl_state_t;

  localparam int DEF_BOOT_CYCLES      = 4;
  localparam int DEF_REDIRECT_BUBBLES = 1;
  localparam int DEF_MEM_TIMEOUT      = 255;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. 'done' reports whether the value the counter
// takes at the next edge has reached 'target', so a caller can leave a
// state on the same edge the count lands on its terminal value.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] target,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise step up until LIMIT and hold there.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q < WIDTH'(LIMIT))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  assign done = (count_d >= target);

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencer for the IF -> EX -> WB core. Owns the EX/WB valid bits, PC
// stall/redirect and the data-memory request, inserting bubbles for boot,
// taken jumps, fetch misses and data-memory back-pressure.
// Optional build macro: PIPELINE_CTRL_PERF_EN adds stall/redirect counters.
module pipeline_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES      = DEF_BOOT_CYCLES,
  parameter int REDIRECT_BUBBLES = DEF_REDIRECT_BUBBLES,
  parameter int MEM_TIMEOUT      = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic        ex_do_jump,
  input  logic        ex_mem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        pc_redirect,
  output logic        ex_en,
  output logic        ex_valid,
  output logic        wb_valid,
  output logic        dmem_req,
  output logic        mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  // One counter serves both boot and redirect since they never overlap.
  localparam int SEQ_MAX = (BOOT_CYCLES > REDIRECT_BUBBLES) ? BOOT_CYCLES : REDIRECT_BUBBLES;
  localparam int SEQ_W   = cnt_width(SEQ_MAX);
  localparam int WAIT_W  = cnt_width(MEM_TIMEOUT);
  localparam bit TIMEOUT_ON = (MEM_TIMEOUT != 0);

  ctrl_state_t state_q, state_d;
  logic        ex_valid_q, ex_valid_d;
  logic        wb_valid_q, wb_valid_d;
  logic        timeout_q;
  logic        seq_clear, seq_en, seq_done;
  logic        wait_done;
  logic        mem_stall;
  logic [SEQ_W-1:0] seq_target;

  assign seq_target = (state_q == BOOT) ? SEQ_W'(BOOT_CYCLES) : SEQ_W'(REDIRECT_BUBBLES);

  sat_counter #(
    .WIDTH (SEQ_W),
    .LIMIT (SEQ_MAX)
  ) u_seq_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (seq_clear),
    .enable (seq_en),
    .target (seq_target),
    .done   (seq_done)
  );

  sat_counter #(
    .WIDTH (WAIT_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != MEM_WAIT),
    .enable (state_q == MEM_WAIT),
    .target (WAIT_W'(MEM_TIMEOUT)),
    .done   (wait_done)
  );

  // Next-state and per-cycle pipeline controls. A memory stall outranks a
  // jump; on memory release the PC advances like a normal cycle so the
  // instruction loaded into EX is not fetched twice.
  always_comb begin
    state_d     = state_q;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    ex_en       = 1'b1;
    dmem_req    = 1'b0;
    ex_valid_d  = ex_valid_q;
    wb_valid_d  = 1'b0;
    seq_clear   = 1'b0;
    seq_en      = 1'b0;
    mem_stall   = 1'b0;
    unique case (state_q)
      BOOT: begin
        pc_stall   = 1'b1;
        ex_valid_d = 1'b0;
        seq_en     = 1'b1;
        if (seq_done) state_d = RUN;
      end
      RUN: begin
        dmem_req  = ex_valid_q & ex_mem_req;
        mem_stall = ex_valid_q & ex_mem_req & ~dmem_ready;
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          pc_stall   = 1'b1;
          ex_en      = 1'b0;
          ex_valid_d = ex_valid_q;
          wb_valid_d = 1'b0;
        end else if (ex_valid_q && ex_do_jump) begin
          pc_redirect = 1'b1;
          pc_stall    = 1'b0;
          ex_valid_d  = 1'b0;
          wb_valid_d  = 1'b1;
          if (REDIRECT_BUBBLES != 0) begin
            state_d   = REDIRECT;
            seq_clear = 1'b1;
          end
        end else begin
          pc_stall   = ~imem_valid;
          ex_valid_d = imem_valid;
          wb_valid_d = ex_valid_q;
        end
      end
      REDIRECT: begin
        pc_stall   = ~imem_valid;
        ex_valid_d = 1'b0;
        wb_valid_d = ex_valid_q;
        seq_en     = imem_valid;
        if (seq_done) state_d = RUN;
      end
      MEM_WAIT: begin
        dmem_req   = 1'b1;
        pc_stall   = 1'b1;
        ex_en      = 1'b0;
        ex_valid_d = ex_valid_q;
        wb_valid_d = 1'b0;
        if (dmem_ready) begin
          wb_valid_d = 1'b1;
          ex_en      = 1'b1;
          ex_valid_d = imem_valid;
          pc_stall   = ~imem_valid;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, valid bits and the sticky memory-timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      ex_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      wb_valid_q <= wb_valid_d;
      if (TIMEOUT_ON && wait_done) timeout_q <= 1'b1;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign wb_valid    = wb_valid_q;
  assign mem_timeout = timeout_q;

`ifdef PIPELINE_CTRL_PERF_EN
  // Free-running event counters: stalls after boot and redirect pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (pc_stall && (state_q != BOOT)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (pc_redirect) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
